// File: rtl/mem_wb_pipe.sv
// DEPTH-stage elastic MEM/WB pipe driving the register-file write port.
// Optional MEM_WB_FWD_EN adds a combinational forwarding lookup.
module mem_wb_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int WB_W   = 2,
  parameter int DEPTH  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [ADDR_W-1:0] rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   wb_o,
  output logic              reg_write_o,
  output logic              mem_to_reg_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [ADDR_W-1:0] rd_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [2:0]        occupancy_o
`ifdef MEM_WB_FWD_EN
  ,
  input  logic [ADDR_W-1:0] fwd_rs_i,
  output logic              fwd_hit_o,
  output logic [DATA_W-1:0] fwd_data_o
`endif
);

  localparam int L = DEPTH - 1;

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [WB_W-1:0]   wb_q    [DEPTH];
  logic [WB_W-1:0]   wb_d    [DEPTH];
  logic [DATA_W-1:0] rdata_q [DEPTH];
  logic [DATA_W-1:0] rdata_d [DEPTH];
  logic [DATA_W-1:0] alu_q   [DEPTH];
  logic [DATA_W-1:0] alu_d   [DEPTH];
  logic [ADDR_W-1:0] rd_q    [DEPTH];
  logic [ADDR_W-1:0] rd_d    [DEPTH];
  logic [2:0]        occ_q, occ_d;

  logic [DEPTH-1:0]  adv;
  logic [DEPTH:0]    nxt_free;
  logic              acc;
  logic              xfer;

  always_comb begin
    // free[k]: stage k can take a new entry this cycle
    nxt_free[DEPTH] = out_ready_i;
    adv = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      adv[k]      = valid_q[k] & nxt_free[k+1];
      nxt_free[k] = ~valid_q[k] | adv[k];
    end
    acc  = in_valid_i & nxt_free[0];
    xfer = adv[L];

    valid_d = valid_q;
    wb_d    = wb_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    rd_d    = rd_q;

    valid_d[0] = acc | (valid_q[0] & ~adv[0]);
    if (acc) begin
      wb_d[0]    = wb_i;
      rdata_d[0] = read_data_i;
      alu_d[0]   = alu_i;
      rd_d[0]    = rd_i;
    end
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = adv[k-1] | (valid_q[k] & ~adv[k]);
      if (adv[k-1]) begin
        wb_d[k]    = wb_q[k-1];
        rdata_d[k] = rdata_q[k-1];
        alu_d[k]   = alu_q[k-1];
        rd_d[k]    = rd_q[k-1];
      end
    end

    occ_d = occ_q + {2'b00, acc} - {2'b00, xfer};
    if (flush_i) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      occ_q   <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        wb_q[k]    <= '0;
        rdata_q[k] <= '0;
        alu_q[k]   <= '0;
        rd_q[k]    <= '0;
      end
    end else begin
      valid_q <= valid_d;
      occ_q   <= occ_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    in_ready_o   = nxt_free[0];
    out_valid_o  = valid_q[L];
    wb_o         = wb_q[L];
    reg_write_o  = wb_q[L][WB_W-1] & valid_q[L];
    mem_to_reg_o = wb_q[L][0];
    read_data_o  = rdata_q[L];
    alu_o        = alu_q[L];
    rd_o         = rd_q[L];
    wr_data_o    = wb_q[L][0] ? rdata_q[L] : alu_q[L];
    occupancy_o  = occ_q;
  end

`ifdef MEM_WB_FWD_EN
  // scan oldest to youngest so the lowest-index match wins
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && wb_q[k][WB_W-1] &&
          rd_q[k] == fwd_rs_i && fwd_rs_i != '0) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = wb_q[k][0] ? rdata_q[k] : alu_q[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed bench for mem_wb_pipe: DEPTH=2 (u_a) and DEPTH=3 (u_b).
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [1:0]  wb;
  logic [31:0] rdata, alu;
  logic [4:0]  rd, fwd_rs;

  logic        a_in_ready, a_out_valid, a_reg_write, a_m2r;
  logic [1:0]  a_wb;
  logic [31:0] a_rdata, a_alu, a_wr_data;
  logic [4:0]  a_rd;
  logic [2:0]  a_occ;
  logic        a_hit;
  logic [31:0] a_fdata;

  logic        b_in_ready, b_out_valid, b_reg_write, b_m2r;
  logic [1:0]  b_wb;
  logic [31:0] b_rdata, b_alu, b_wr_data;
  logic [4:0]  b_rd;
  logic [2:0]  b_occ;
  logic        b_hit;
  logic [31:0] b_fdata;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_wb_pipe #(.DEPTH(2)) u_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .wb_i(wb), .read_data_i(rdata), .alu_i(alu), .rd_i(rd),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready),
    .wb_o(a_wb), .reg_write_o(a_reg_write), .mem_to_reg_o(a_m2r),
    .read_data_o(a_rdata), .alu_o(a_alu), .rd_o(a_rd),
    .wr_data_o(a_wr_data), .occupancy_o(a_occ)
`ifdef MEM_WB_FWD_EN
    , .fwd_rs_i(fwd_rs), .fwd_hit_o(a_hit), .fwd_data_o(a_fdata)
`endif
  );

  mem_wb_pipe #(.DEPTH(3)) u_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .wb_i(wb), .read_data_i(rdata), .alu_i(alu), .rd_i(rd),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready),
    .wb_o(b_wb), .reg_write_o(b_reg_write), .mem_to_reg_o(b_m2r),
    .read_data_o(b_rdata), .alu_o(b_alu), .rd_o(b_rd),
    .wr_data_o(b_wr_data), .occupancy_o(b_occ)
`ifdef MEM_WB_FWD_EN
    , .fwd_rs_i(fwd_rs), .fwd_hit_o(b_hit), .fwd_data_o(b_fdata)
`endif
  );

`ifndef MEM_WB_FWD_EN
  assign a_hit = 1'b0;
  assign a_fdata = '0;
  assign b_hit = 1'b0;
  assign b_fdata = '0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] w, input logic [31:0] r,
                     input logic [31:0] a, input logic [4:0] d);
    in_valid = 1'b1;
    wb = w;
    rdata = r;
    alu = a;
    rd = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    wb = '0; rdata = '0; alu = '0; rd = '0; fwd_rs = '0;

    // reset state
    do_reset();
    chk("rst_out_valid", {31'b0, a_out_valid}, 32'd0);
    chk("rst_reg_write", {31'b0, a_reg_write}, 32'd0);
    chk("rst_wr_data", a_wr_data, 32'd0);
    chk("rst_occ_a", {29'b0, a_occ}, 32'd0);
    chk("rst_occ_b", {29'b0, b_occ}, 32'd0);
    chk("rst_in_ready", {31'b0, a_in_ready}, 32'd1);

    // lw passthrough, DEPTH=2
    put(2'b11, 32'hDEADBEEF, 32'h100, 5'd8);
    tick();
    in_valid = 1'b0;
    #1;
    chk("lw_lat1_valid", {31'b0, a_out_valid}, 32'd0);
    tick();
    chk("lw_valid", {31'b0, a_out_valid}, 32'd1);
    chk("lw_reg_write", {31'b0, a_reg_write}, 32'd1);
    chk("lw_wr_data", a_wr_data, 32'hDEADBEEF);
    chk("lw_rd", {27'b0, a_rd}, 32'd8);
    chk("lw_occ", {29'b0, a_occ}, 32'd1);
    tick();
    chk("lw_drained", {31'b0, a_out_valid}, 32'd0);
    chk("lw_occ0", {29'b0, a_occ}, 32'd0);

    // stall fill, DEPTH=3
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(2'b10, 32'h0, 32'hA0 + i, 5'(i + 1));
      #1;
      chk("fill_ready", {31'b0, b_in_ready}, 32'd1);
      tick();
    end
    put(2'b10, 32'h0, 32'hA3, 5'd4);
    #1;
    chk("full_ready", {31'b0, b_in_ready}, 32'd0);
    chk("full_occ", {29'b0, b_occ}, 32'd3);
    tick();
    chk("hold_occ", {29'b0, b_occ}, 32'd3);
    chk("hold_alu", b_alu, 32'hA0);
    chk("hold_rd", {27'b0, b_rd}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("release_ready", {31'b0, b_in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("drain_occ", {29'b0, b_occ}, 32'd3);
    chk("drain1", b_alu, 32'hA1);
    tick();
    chk("drain2", b_alu, 32'hA2);
    tick();
    chk("drain3", b_alu, 32'hA3);
    chk("drain3_rd", {27'b0, b_rd}, 32'd4);
    chk("drain3_valid", {31'b0, b_out_valid}, 32'd1);
    tick();
    chk("drain_empty", {31'b0, b_out_valid}, 32'd0);
    chk("drain_occ0", {29'b0, b_occ}, 32'd0);

    // flush, DEPTH=2
    do_reset();
    out_ready = 1'b0;
    put(2'b10, 32'h0, 32'h31, 5'd1);
    tick();
    put(2'b10, 32'h0, 32'h32, 5'd2);
    tick();
    chk("pre_flush_occ", {29'b0, a_occ}, 32'd2);
    out_ready = 1'b1;
    flush = 1'b1;
    put(2'b10, 32'h0, 32'h99, 5'd9);
    #1;
    chk("flush_ready", {31'b0, a_in_ready}, 32'd1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("flush_occ", {29'b0, a_occ}, 32'd0);
    chk("flush_reg_write", {31'b0, a_reg_write}, 32'd0);
    tick();
    tick();
    chk("flush_no_ghost", {31'b0, a_out_valid}, 32'd0);
    chk("flush_occ_late", {29'b0, a_occ}, 32'd0);

    // bubble then real write, DEPTH=2
    do_reset();
    put(2'b00, 32'h0, 32'h55, 5'd3);
    tick();
    put(2'b10, 32'h0, 32'h77, 5'd4);
    tick();
    in_valid = 1'b0;
    #1;
    chk("nop_valid", {31'b0, a_out_valid}, 32'd1);
    chk("nop_reg_write", {31'b0, a_reg_write}, 32'd0);
    chk("nop_wr_data", a_wr_data, 32'h55);
    tick();
    chk("b2b_wr_data", a_wr_data, 32'h77);
    chk("b2b_reg_write", {31'b0, a_reg_write}, 32'd1);
    tick();
    chk("stale_reg_write", {31'b0, a_reg_write}, 32'd0);
    chk("stale_valid", {31'b0, a_out_valid}, 32'd0);

`ifdef MEM_WB_FWD_EN
    do_reset();
    out_ready = 1'b0;
    put(2'b10, 32'h0, 32'h11, 5'd5);
    tick();
    put(2'b10, 32'h0, 32'h22, 5'd5);
    tick();
    in_valid = 1'b0;
    fwd_rs = 5'd5;
    #1;
    chk("fwd_hit", {31'b0, a_hit}, 32'd1);
    chk("fwd_young", a_fdata, 32'h22);
    fwd_rs = 5'd0;
    #1;
    chk("fwd_x0_hit", {31'b0, a_hit}, 32'd0);
    chk("fwd_x0_data", a_fdata, 32'd0);
    fwd_rs = 5'd7;
    #1;
    chk("fwd_miss", {31'b0, a_hit}, 32'd0);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
